// File: rtl/firebird7_in_gate1_tessent_tdr_observe_w3_if.sv
// IJTAG scan-path port bundle for the observe TDR: enables and serial data in, serial data out.
// Signal names match the standard IJTAG port names so network stitching stays readable.
interface firebird7_in_gate1_tessent_tdr_observe_w3_if;
  logic ijtag_sel;
  logic ijtag_ce;
  logic ijtag_se;
  logic ijtag_ue;
  logic ijtag_si;
  logic ijtag_so;

  modport master (
    output ijtag_sel,
    output ijtag_ce,
    output ijtag_se,
    output ijtag_ue,
    output ijtag_si,
    input  ijtag_so
  );

  modport slave (
    input  ijtag_sel,
    input  ijtag_ce,
    input  ijtag_se,
    input  ijtag_ue,
    input  ijtag_si,
    output ijtag_so
  );
endinterface

// File: rtl/firebird7_in_gate1_tessent_tdr_observe_w3.sv
// Observe/drive TDR: captures functional data, shifts it out, and updates a data/select mux control.
// Updates take effect one tck after ue; an update is accepted only after exactly WIDTH+1 shifts.
module firebird7_in_gate1_tessent_tdr_observe_w3 #(
  parameter int WIDTH = 3
) (
  input  logic                                         ijtag_tck,
  input  logic                                         ijtag_reset,
  firebird7_in_gate1_tessent_tdr_observe_w3_if.slave   scan,
  input  logic [WIDTH-1:0]                             observe_data_in,
  output logic [WIDTH-1:0]                             ijtag_data_out,
  output logic                                         ijtag_select_out,
  output logic                                         shift_count_error
);

  localparam int CW = $clog2(WIDTH + 3);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH + 1);
  localparam logic [CW-1:0] CNT_SAT  = CW'(WIDTH + 2);

  logic [WIDTH:0]   r_sr;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_data_out;
  logic             r_select_out;
  logic             r_err;

  logic w_capture;
  logic w_shift;
  logic w_update;
  logic w_update_ok;

  // Capture wins over shift, shift over update; nothing happens unless selected.
  assign w_capture   = scan.ijtag_sel & scan.ijtag_ce;
  assign w_shift     = scan.ijtag_sel & scan.ijtag_se & ~scan.ijtag_ce;
  assign w_update    = scan.ijtag_sel & scan.ijtag_ue & ~scan.ijtag_ce & ~scan.ijtag_se;
  assign w_update_ok = w_update & (r_cnt == CNT_FULL);

  always_ff @(posedge ijtag_tck or posedge ijtag_reset) begin
    if (ijtag_reset) begin
      r_sr         <= '0;
      r_cnt        <= '0;
      r_data_out   <= '0;
      r_select_out <= 1'b0;
      r_err        <= 1'b0;
    end else if (w_capture) begin
      r_sr  <= {r_select_out, observe_data_in};
      r_cnt <= '0;
      r_err <= 1'b0;
    end else if (w_shift) begin
      r_sr <= {scan.ijtag_si, r_sr[WIDTH:1]};
      // Saturate so an over-long shift can never alias back to a legal length.
      if (r_cnt != CNT_SAT) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end else if (w_update) begin
      if (w_update_ok) begin
        r_select_out <= r_sr[WIDTH];
        r_data_out   <= r_sr[WIDTH-1:0];
        r_cnt        <= '0;
      end else begin
        r_err <= 1'b1;
      end
    end
  end

  assign scan.ijtag_so     = r_sr[0];
  assign ijtag_data_out    = r_data_out;
  assign ijtag_select_out  = r_select_out;
  assign shift_count_error = r_err;

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_tdr_observe_w3.sv
// Directed bench for the observe TDR: capture/shift/update sequences, length checks and async reset.
module tb_firebird7_in_gate1_tessent_tdr_observe_w3;

  logic       ijtag_tck;
  logic       ijtag_reset;
  logic [2:0] observe_data_in;
  logic [2:0] ijtag_data_out;
  logic       ijtag_select_out;
  logic       shift_count_error;

  int checks = 0;
  int errors = 0;

  firebird7_in_gate1_tessent_tdr_observe_w3_if u_if ();

  firebird7_in_gate1_tessent_tdr_observe_w3 #(.WIDTH(3)) u_dut (
    .ijtag_tck         (ijtag_tck),
    .ijtag_reset       (ijtag_reset),
    .scan              (u_if),
    .observe_data_in   (observe_data_in),
    .ijtag_data_out    (ijtag_data_out),
    .ijtag_select_out  (ijtag_select_out),
    .shift_count_error (shift_count_error)
  );

  initial ijtag_tck = 1'b0;
  always #5 ijtag_tck = ~ijtag_tck;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply enables for one tck edge, then return 1 time unit after that edge.
  task automatic step(input logic sel, input logic ce, input logic se, input logic ue, input logic si);
    u_if.ijtag_sel = sel;
    u_if.ijtag_ce  = ce;
    u_if.ijtag_se  = se;
    u_if.ijtag_ue  = ue;
    u_if.ijtag_si  = si;
    @(posedge ijtag_tck);
    #1;
  endtask

  task automatic chk_outs(input string tag, input logic sel_o, input logic [2:0] dat_o, input logic err);
    chk({tag, "_sel"}, 32'(ijtag_select_out), 32'(sel_o));
    chk({tag, "_dat"}, 32'(ijtag_data_out), 32'(dat_o));
    chk({tag, "_err"}, 32'(shift_count_error), 32'(err));
  endtask

  initial begin
    ijtag_reset     = 1'b1;
    observe_data_in = 3'b000;
    u_if.ijtag_sel  = 1'b0;
    u_if.ijtag_ce   = 1'b0;
    u_if.ijtag_se   = 1'b0;
    u_if.ijtag_ue   = 1'b0;
    u_if.ijtag_si   = 1'b0;
    #12;
    chk_outs("reset", 1'b0, 3'b000, 1'b0);
    chk("reset_so", 32'(u_if.ijtag_so), 32'd0);
    ijtag_reset = 1'b0;

    // Capture 101 and shift out with si=0: so shows 1,0,1,0
    observe_data_in = 3'b101;
    step(1, 1, 0, 0, 0);
    chk("cap_so0", 32'(u_if.ijtag_so), 32'd1);
    step(1, 0, 1, 0, 0);
    chk("shf_so1", 32'(u_if.ijtag_so), 32'd0);
    step(1, 0, 1, 0, 0);
    chk("shf_so2", 32'(u_if.ijtag_so), 32'd1);
    step(1, 0, 1, 0, 0);
    chk("shf_so3", 32'(u_if.ijtag_so), 32'd0);
    step(1, 0, 1, 0, 0);
    chk_outs("shift_no_upd", 1'b0, 3'b000, 1'b0);

    // Capture, shift 1,1,0,1 -> SR=1011, update
    observe_data_in = 3'b000;
    step(1, 1, 0, 0, 0);
    step(1, 0, 1, 0, 1);
    step(1, 0, 1, 0, 1);
    step(1, 0, 1, 0, 0);
    step(1, 0, 1, 0, 1);
    chk_outs("pre_upd", 1'b0, 3'b000, 1'b0);
    step(1, 0, 0, 1, 0);
    chk_outs("upd_ok", 1'b1, 3'b011, 1'b0);
    step(1, 0, 0, 1, 0);
    chk_outs("upd_twice", 1'b1, 3'b011, 1'b1);

    // Capture clears flag; 3 shifts then update is rejected
    observe_data_in = 3'b010;
    step(1, 1, 0, 0, 0);
    chk_outs("cap_clr", 1'b1, 3'b011, 1'b0);
    chk("cap_so_sel", 32'(u_if.ijtag_so), 32'd0);
    step(1, 0, 1, 0, 1);
    step(1, 0, 1, 0, 1);
    step(1, 0, 1, 0, 1);
    step(1, 0, 0, 1, 0);
    chk_outs("short_upd", 1'b1, 3'b011, 1'b1);
    step(1, 0, 0, 1, 0);
    chk_outs("sticky_rej", 1'b1, 3'b011, 1'b1);
    step(1, 1, 0, 0, 0);
    chk_outs("cap_clr2", 1'b1, 3'b011, 1'b0);

    // 6 shifts -> counter saturated, rejected
    for (int i = 0; i < 6; i++) step(1, 0, 1, 0, 0);
    step(1, 0, 0, 1, 0);
    chk_outs("long6_upd", 1'b1, 3'b011, 1'b1);

    // 12 shifts: a 3-bit wrapping counter would read 4 here
    step(1, 1, 0, 0, 0);
    for (int i = 0; i < 12; i++) step(1, 0, 1, 0, 0);
    step(1, 0, 0, 1, 0);
    chk_outs("long12_upd", 1'b1, 3'b011, 1'b1);

    // ce and se together: capture only, counter restarts at 0
    observe_data_in = 3'b010;
    step(1, 1, 1, 0, 1);
    chk("cese_so", 32'(u_if.ijtag_so), 32'd0);
    chk("cese_err", 32'(shift_count_error), 32'd0);
    step(1, 0, 1, 0, 1);
    chk("cese_shf_so", 32'(u_if.ijtag_so), 32'd1);
    step(1, 0, 1, 0, 1);
    step(1, 0, 1, 0, 1);
    step(1, 0, 1, 0, 1);
    step(1, 0, 0, 1, 0);
    chk_outs("upd_111", 1'b1, 3'b111, 1'b0);

    // Async reset between edges clears everything immediately
    #2;
    ijtag_reset = 1'b1;
    #1;
    chk_outs("async_rst", 1'b0, 3'b000, 1'b0);
    chk("async_rst_so", 32'(u_if.ijtag_so), 32'd0);
    #1;
    ijtag_reset = 1'b0;
    step(1, 0, 0, 1, 0);
    chk_outs("post_rst_upd", 1'b0, 3'b000, 1'b1);

    // Deselected: capture enable ignored, state held
    step(0, 1, 0, 0, 0);
    chk_outs("desel_hold", 1'b0, 3'b000, 1'b1);

    // Reset mid-shift discards partial count (2+2 shifts must not be accepted)
    observe_data_in = 3'b000;
    step(1, 1, 0, 0, 0);
    step(1, 0, 1, 0, 1);
    step(1, 0, 1, 0, 1);
    #2;
    ijtag_reset = 1'b1;
    #2;
    ijtag_reset = 1'b0;
    step(1, 0, 1, 0, 1);
    step(1, 0, 1, 0, 1);
    step(1, 0, 0, 1, 0);
    chk_outs("midshift_rst", 1'b0, 3'b000, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/firebird7_in_gate1_tessent_tdr_observe_w3.md
FIREBIRD7_IN_GATE1_TESSENT_TDR_OBSERVE_W3 -- requirements
Module: firebird7_in_gate1_tessent_tdr_observe_w3

Interface
REQ-001 Parameter WIDTH SHALL be: WIDTH, default 3, number of functional data bits observed and driven.
REQ-002 Port ijtag_tck SHALL be: ijtag_tck  input  1  the single clock; all state updates on its rising edge.
REQ-003 Port ijtag_reset SHALL be: ijtag_reset  input  1  reset, asynchronous and active-high.
REQ-004 Port ijtag_sel SHALL be: ijtag_sel  input  1  TDR selected on scan path; all enables are ignored when 0.
REQ-005 Port ijtag_ce SHALL be: ijtag_ce  input  1  capture enable.
REQ-006 Port ijtag_se SHALL be: ijtag_se  input  1  shift enable.
REQ-007 Port ijtag_ue SHALL be: ijtag_ue  input  1  update enable.
REQ-008 Port ijtag_si SHALL be: ijtag_si  input  1  scan in.
REQ-009 Port ijtag_so SHALL be: ijtag_so  output  1  scan out.
REQ-010 Port observe_data_in SHALL be: observe_data_in  input  WIDTH  functional data_out observed by capture.
REQ-011 Port ijtag_data_out SHALL be: ijtag_data_out  output  WIDTH  updated value, drives the data mux ijtag_data_in.
REQ-012 Port ijtag_select_out SHALL be: ijtag_select_out  output  1  updated select, drives the data mux ijtag_select.
REQ-013 Port shift_count_error SHALL be: shift_count_error  output  1  sticky flag set when an update is rejected for a wrong shift length.

Function
REQ-014 The shift register SR SHALL be WIDTH+1 bits: SR[WIDTH] is the select bit and SR[WIDTH-1:0] is data; ijtag_so SHALL equal SR[0] combinationally.
REQ-015 Enable priority when ijtag_sel=1 SHALL be capture > shift > update; exactly one action occurs per cycle.
REQ-016 Capture (sel & ce) SHALL load SR <= {ijtag_select_out, observe_data_in}, clear the shift counter to 0, and clear shift_count_error, all in the same edge.
REQ-017 Shift (sel & se & !ce) SHALL load SR <= {ijtag_si, SR[WIDTH:1]} (LSB out first) and increment the shift counter.
REQ-018 The shift counter SHALL saturate at WIDTH+2; it SHALL never wrap, and it SHALL be at least ceil(log2(WIDTH+3)) bits wide.
REQ-019 Update (sel & ue & !ce & !se) with counter == WIDTH+1 SHALL load ijtag_select_out <= SR[WIDTH] and ijtag_data_out <= SR[WIDTH-1:0] on that edge; the outputs are visible one cycle after ue is sampled.
REQ-020 Update with counter != WIDTH+1 SHALL leave ijtag_data_out and ijtag_select_out unchanged and SHALL set shift_count_error to 1.
REQ-021 An accepted update SHALL reset the counter to 0, so a second update without a new shift is rejected and flags an error.
REQ-022 shift_count_error SHALL remain set until the next capture or reset; a rejected update SHALL NOT clear it.
REQ-023 When ijtag_sel=0, SR, the counter, the outputs and the flag SHALL hold their values, and ijtag_so SHALL still present SR[0].
REQ-024 The updated registers SHALL change only on an accepted update or on reset; shift and capture SHALL never disturb ijtag_data_out or ijtag_select_out.

Reset
REQ-025 While ijtag_reset=1, the block SHALL asynchronously force SR=0, counter=0, ijtag_data_out=0, ijtag_select_out=0 and shift_count_error=0, so the mux selects functional data.
REQ-026 Reset asserted mid-shift SHALL discard the partial shift; after release, an update without a fresh capture+shift SHALL be rejected.

Verification
REQ-027 The bench SHALL cover: reset, then sel=1, ce pulse with observe_data_in=3'b101, then 4 shifts with si=0 -> so sequence 1,0,1,0 (select bit 0 last).
REQ-028 The bench SHALL cover: capture, then 4 shifts of si=1,1,0,1 (first in ends at SR[0]), then ue -> ijtag_select_out=1 and ijtag_data_out=3'b011 one cycle later, with error=0.
REQ-029 The bench SHALL cover: capture, then 3 shifts, then ue -> outputs unchanged and shift_count_error=1; a following capture clears the flag to 0.
REQ-030 The bench SHALL cover: capture, then 6 shifts, then ue -> counter saturated at 5, update rejected and error=1.
REQ-031 The bench SHALL cover: ce and se high together for one cycle -> a capture occurs, SR is not shifted, and the counter is 0.
REQ-032 The bench SHALL cover: an accepted update to data=3'b111 and select=1, then ijtag_reset pulsed asynchronously between clock edges -> all outputs 0 immediately, before the next ijtag_tck edge.
